block_move_unit: RTL and testbench
==================================

Name: block_move_unit

Overview:
Parametrised successor to the single-register MOV op. It holds a WIDTH x DEPTH register bank with a CPU write port and a CPU read port. A sequential move engine copies a contiguous run of COUNT registers from SrcAddr to DstAddr, one word per clock. Overlapping runs are copied safely, with the same result as memmove. It sits beside the ALU and services block-MOV instructions, with the CPU stalling on Busy.

Parameters:
WIDTH, 16, data width of each register
DEPTH, 16, number of registers; must be a power of two, at least 2
ADDR_W, $clog2(DEPTH), derived; index width, not overridable

Ports:
Clock  input  1  system clock; all state updates on the rising edge
ResetN  input  1  synchronous, active-low reset, sampled on the rising edge of Clock
WrEn  input  1  CPU write strobe
WrAddr  input  ADDR_W  CPU write index
WrData  input  WIDTH  CPU write data
RdAddr  input  ADDR_W  CPU read index
RdData  output  WIDTH  combinational read, equal to bank[RdAddr]
Start  input  1  request a block move; sampled only in IDLE
SrcAddr  input  ADDR_W  first source index
DstAddr  input  ADDR_W  first destination index
Count  input  ADDR_W+1  number of words to move, 0..DEPTH
Busy  output  1  high while the engine owns the bank
Done  output  1  one-cycle pulse when a request finishes (success, empty or error)
Error  output  1  one-cycle pulse, coincident with Done, on a range violation

Behaviour:
- Reset (ResetN=0 at an edge):
  - All bank words go to 0 and the FSM goes to IDLE.
  - Busy=0, Done=0, Error=0.
  - Reset mid-move aborts immediately; no further writes and no Done.
- FSM states: IDLE, COPY, FINISH.
- IDLE, Start=1:
  - Latch src, dst and count.
  - If Src+Count>DEPTH or Dst+Count>DEPTH, using an ADDR_W+1-bit sum: go to FINISH with err=1 and perform no writes.
  - Else if Count=0: go to FINISH with err=0.
  - Else go to COPY. Direction is descending when Dst>Src, otherwise ascending.
  - Pointers: ascending starts at src/dst; descending starts at src+count-1/dst+count-1.
- COPY, one word per cycle:
  - bank[dptr] <= bank[sptr].
  - Pointers step by +1 (ascending) or -1 (descending); remaining count decrements.
  - When remaining=1, the write happens and the FSM goes to FINISH.
- FINISH: Done=1, Error=err, then return to IDLE.
- Busy is registered: 1 in COPY and FINISH, 0 in IDLE.
- Timing: Start accepted at edge k; first copy write at edge k+1; last at edge k+N; Done is high during the cycle after edge k+N+1. Zero-count and error requests show Done in the cycle after edge k+1.
- Start while Busy is ignored; no queueing.
- Start together with WrEn in IDLE: the CPU write commits at the same edge, before the first copy read (the copy reads at edge k+1).
- WrEn while Busy=1 is dropped. The CPU must stall on Busy.
- WrEn in IDLE: bank[WrAddr] <= WrData.
- RdData is combinational and reflects a write from the following cycle onward.
- Src==Dst with Count>0 still runs N COPY cycles; the data is unchanged.
- No address wrap-around. Every out-of-range request is rejected via Error.

Decomposition:
- Shared package cpu_pkg: WIDTH and DEPTH defaults, and the FSM state enum move_state_t (IDLE, COPY, FINISH).
- One sub-module, block_move_bank: a DEPTH x WIDTH register array with synchronous clear, one write port (muxed between CPU and engine by the top) and two combinational read ports (RdAddr and the engine's sptr).
- The FSM, pointer/count logic and range check stay in the top.

Test Plan:
- Reset/basic move: ResetN low for 2 cycles → RdData=0 at every index. Write bank[i]=0x1000+i for i=0..15. Start Src=2, Dst=8, Count=4 → Busy for 5 cycles, Done one cycle. bank[8..11]=0x1002..0x1005; bank[2..5] unchanged; all other words unchanged.
- Overlap, ascending: same fill. Src=4, Dst=2, Count=6 → bank[2..7]=0x1004..0x1009.
- Overlap, descending: same fill. Src=2, Dst=4, Count=6 → bank[4..9]=0x1002..0x1007 with no smeared repeats; bank[2..3] unchanged.
- Boundaries:
  - Count=0 → Done one cycle after Start, Error=0, no writes.
  - Src=12, Count=5 → Done and Error together, no writes.
  - Src=0, Dst=0, Count=16 → success, bank unchanged.
- Contention: during a move, pulse Start with other operands and WrEn=1, WrAddr=0, WrData=0xBEEF → both ignored; bank[0] unchanged; exactly one Done.
- Reset mid-move: start Src=0, Dst=8, Count=8 and assert ResetN=0 after 3 copy cycles → next cycle Busy=0, Done=0, all words 0. A new request after reset completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: default bank geometry and the block-move FSM state encoding.
package cpu_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    FINISH = 2'd2
  } move_state_t;
endpackage

// File: rtl/block_move_bank.sv
// DEPTH x WIDTH register array: synchronous clear, one write port, two combinational read ports.
module block_move_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/block_move_unit.sv
// Block-MOV engine: register bank plus a one-word-per-cycle, overlap-safe (memmove) copy FSM.
module block_move_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [WIDTH-1:0]  RdData,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W:0]   Count,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output move_state_t       DbgState
);
  // Handshake: Start is taken only while the FSM is IDLE; Busy covers every cycle the
  // engine owns the bank (COPY and FINISH), and Done (with Error on a rejected range)
  // pulses for exactly one cycle after Busy falls. Writes and Starts seen while Busy are dropped.
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  move_state_t       state;
  logic [ADDR_W-1:0] sptr, dptr;
  logic [ADDR_W:0]   remaining;
  logic              desc, err;

  logic [ADDR_W:0]   src_end, dst_end;
  logic              range_bad, go_desc;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [WIDTH-1:0]  bank_wdata, src_word;

  assign src_end   = {1'b0, SrcAddr} + Count;
  assign dst_end   = {1'b0, DstAddr} + Count;
  assign range_bad = (src_end > DEPTH_W) || (dst_end > DEPTH_W);
  // Copy from the top down when the destination sits above the source, so no word is read after being overwritten.
  assign go_desc   = DstAddr > SrcAddr;

  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = WrAddr;
    bank_wdata = WrData;
    if (state == COPY) begin
      bank_we    = 1'b1;
      bank_waddr = dptr;
      bank_wdata = src_word;
    end else if (state == IDLE) begin
      bank_we    = WrEn;
    end
  end

  block_move_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
    .clk     (Clock),
    .rst_n   (ResetN),
    .we      (bank_we),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .raddr_a (RdAddr),
    .rdata_a (RdData),
    .raddr_b (sptr),
    .rdata_b (src_word)
  );

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state     <= IDLE;
      sptr      <= '0;
      dptr      <= '0;
      remaining <= '0;
      desc      <= 1'b0;
      err       <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            err       <= range_bad;
            desc      <= go_desc;
            remaining <= Count;
            Busy      <= 1'b1;
            if (go_desc) begin
              sptr <= SrcAddr + ADDR_W'(Count) - ADDR_W'(1);
              dptr <= DstAddr + ADDR_W'(Count) - ADDR_W'(1);
            end else begin
              sptr <= SrcAddr;
              dptr <= DstAddr;
            end
            if (range_bad || Count == '0) state <= FINISH;
            else                          state <= COPY;
          end
        end
        COPY: begin
          sptr      <= desc ? sptr - ADDR_W'(1) : sptr + ADDR_W'(1);
          dptr      <= desc ? dptr - ADDR_W'(1) : dptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          if (remaining == (ADDR_W+1)'(1)) state <= FINISH;
        end
        FINISH: begin
          Done  <= 1'b1;
          Error <= err;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign DbgState = state;
endmodule

// File: tb/tb_block_move_unit.sv
// Directed, table-driven bench for block_move_unit with a memmove reference model.
module tb_block_move_unit;
  import cpu_pkg::*;

  logic        Clock;
  logic        ResetN;
  logic        WrEn;
  logic [3:0]  WrAddr;
  logic [15:0] WrData;
  logic [3:0]  RdAddr;
  logic [15:0] RdData;
  logic        Start;
  logic [3:0]  SrcAddr;
  logic [3:0]  DstAddr;
  logic [4:0]  Count;
  logic        Busy;
  logic        Done;
  logic        Error;
  move_state_t DbgState;

  block_move_unit dut (
    .Clock(Clock), .ResetN(ResetN), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddr(RdAddr), .RdData(RdData), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Count(Count), .Busy(Busy), .Done(Done), .Error(Error), .DbgState(DbgState)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model [16];

  typedef struct {
    int src;
    int dst;
    int cnt;
    bit exp_err;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge Clock);
    ResetN = 1'b0;
    repeat (cycles) @(negedge Clock);
    ResetN = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic fill_bank();
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      WrEn = 1'b1; WrAddr = 4'(i); WrData = 16'(16'h1000 + i);
      model[i] = 16'(16'h1000 + i);
    end
    @(negedge Clock);
    WrEn = 1'b0;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      RdAddr = 4'(i);
      #1;
      check($sformatf("%s bank[%0d]", tag, i), int'(RdData), int'(model[i]));
    end
  endtask

  task automatic model_move(input int s, input int d, input int c);
    logic [15:0] tmp [16];
    tmp = model;
    for (int j = 0; j < c; j++) model[d + j] = tmp[s + j];
  endtask

  // Drives one request and watches the response for a bounded window.
  // contend: pulse a foreign Start plus a CPU write while the engine is busy.
  // wr_with_start: issue a CPU write to bank[0] on the same edge as Start.
  task automatic do_move(input string tag, input int s, input int d, input int c,
                         input bit exp_err, input bit contend, input bit wr_with_start,
                         input logic [15:0] wdat);
    int lat, busy_n, done_n, err_n, exp_lat, exp_busy;
    lat = 0; busy_n = 0; done_n = 0; err_n = 0;
    @(negedge Clock);
    Start = 1'b1; SrcAddr = 4'(s); DstAddr = 4'(d); Count = 5'(c);
    if (wr_with_start) begin
      WrEn = 1'b1; WrAddr = 4'd0; WrData = wdat;
      model[0] = wdat;
    end
    @(negedge Clock);
    Start = 1'b0; WrEn = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (lat == 0) lat = t;
      end
      if (Error) err_n++;
      if (contend && t == 2) begin
        Start = 1'b1; SrcAddr = 4'd0; DstAddr = 4'd1; Count = 5'd3;
        WrEn = 1'b1; WrAddr = 4'd0; WrData = 16'hBEEF;
      end else begin
        Start = 1'b0; WrEn = 1'b0;
      end
      @(negedge Clock);
    end
    if (!exp_err) model_move(s, d, c);
    exp_lat  = (exp_err || c == 0) ? 2 : c + 2;
    exp_busy = (exp_err || c == 0) ? 1 : c + 1;
    check({tag, " done latency"}, lat, exp_lat);
    check({tag, " done pulses"}, done_n, 1);
    check({tag, " busy cycles"}, busy_n, exp_busy);
    check({tag, " error pulses"}, err_n, exp_err ? 1 : 0);
    check_bank(tag);
  endtask

  initial begin
    ResetN = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0; RdAddr = '0;
    Start = 1'b0; SrcAddr = '0; DstAddr = '0; Count = '0;

    vecs[0] = '{2, 8, 4, 1'b0};
    vecs[1] = '{4, 2, 6, 1'b0};
    vecs[2] = '{2, 4, 6, 1'b0};
    vecs[3] = '{3, 5, 0, 1'b0};
    vecs[4] = '{12, 0, 5, 1'b1};
    vecs[5] = '{0, 0, 16, 1'b0};
    vecs[6] = '{0, 5, 12, 1'b1};
    vecs[7] = '{15, 0, 1, 1'b0};
    vecs[8] = '{0, 15, 1, 1'b0};
    vecs[9] = '{7, 7, 5, 1'b0};

    // reset state
    do_reset(2);
    check("reset busy", int'(Busy), 0);
    check("reset done", int'(Done), 0);
    check("reset error", int'(Error), 0);
    check("reset state", int'(DbgState), int'(IDLE));
    check_bank("reset");

    for (int v = 0; v < 10; v++) begin
      do_reset(2);
      fill_bank();
      check_bank($sformatf("fill%0d", v));
      do_move($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].cnt,
              vecs[v].exp_err, 1'b0, 1'b0, 16'h0);
    end

    // contention: foreign Start and CPU write during a move are dropped
    do_reset(2);
    fill_bank();
    do_move("contend", 2, 8, 4, 1'b0, 1'b1, 1'b0, 16'h0);

    // CPU write on the Start edge lands before the first copy read
    do_move("wr_start", 0, 1, 1, 1'b0, 1'b0, 1'b1, 16'hABCD);

    // reset mid-move aborts with no Done and a cleared bank
    do_reset(2);
    fill_bank();
    @(negedge Clock);
    Start = 1'b1; SrcAddr = 4'd0; DstAddr = 4'd8; Count = 5'd8;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    ResetN = 1'b0;
    @(negedge Clock);
    check("midreset busy", int'(Busy), 0);
    check("midreset done", int'(Done), 0);
    check("midreset state", int'(DbgState), int'(IDLE));
    @(negedge Clock);
    ResetN = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    check_bank("midreset");
    repeat (2) begin
      @(negedge Clock);
      check("post-reset no done", int'(Done), 0);
    end
    fill_bank();
    do_move("after_reset", 0, 8, 8, 1'b0, 1'b0, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "timeout");
  end
endmodule
